// File: rtl/moving_average_filter.sv
// Multi-channel boxcar (moving-average) filter for interleaved audio samples.
// Each channel keeps a delay line of 2^WINDOW_LOG2 samples and a running sum.
// The registered output is the windowed mean, or the raw input when bypass
// is set. State updates in both modes.
module moving_average_filter #(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_LOG2 = 3,
  parameter int CHANNELS    = 2,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic        [CW-1:0]         chan_in,
  input  logic                         bypass,
  input  logic                         clear,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic        [CW-1:0]         chan_out,
  output logic                         out_valid
);

  localparam int N  = 1 << WINDOW_LOG2;
  // The running sum needs WINDOW_LOG2 guard bits so it can never overflow.
  localparam int AW = DATA_WIDTH + WINDOW_LOG2;
  localparam logic [CW:0] CH_LIMIT = (CW + 1)'(CHANNELS);

  // Per-channel filter state.
  logic signed [DATA_WIDTH-1:0]  r_line [CHANNELS][N];
  logic        [WINDOW_LOG2-1:0] r_ptr  [CHANNELS];
  logic signed [AW-1:0]          r_acc  [CHANNELS];

  // Registered output stage.
  logic signed [DATA_WIDTH-1:0]  r_sample_out;
  logic        [CW-1:0]          r_chan_out;
  logic                          r_out_valid;

  logic                          w_in_range;
  logic                          w_accept;
  logic        [CW-1:0]          w_chan;
  logic signed [DATA_WIDTH-1:0]  w_oldest;
  logic signed [AW-1:0]          w_acc_next;
  logic signed [DATA_WIDTH-1:0]  w_avg;

  assign w_in_range = ({1'b0, chan_in} < CH_LIMIT);
  assign w_accept   = enable && !clear && w_in_range;

  // Select the addressed channel, compute its new sum and the windowed mean.
  // All state is read from flops, so a sample for the same channel in the
  // following cycle already sees the updated sum and pointer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_chan = '0;
    if (w_in_range) w_chan = chan_in;
    w_oldest   = r_line[w_chan][r_ptr[w_chan]];
    w_acc_next = r_acc[w_chan] + AW'(sample_in) - AW'(w_oldest);
    // The top DATA_WIDTH bits are the sum arithmetically shifted right by
    // WINDOW_LOG2 (floor toward -inf). That value always fits DATA_WIDTH.
    w_avg      = w_acc_next[AW-1:WINDOW_LOG2];
  end

  // Update state on an accepted sample, flush on clear, and register the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the delay lines are reset explicitly, not left to power-up
      // contents. The running sums assume the history starts at zero.
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < N; i++) r_line[c][i] <= '0;
        r_ptr[c] <= '0;
        r_acc[c] <= '0;
      end
      r_sample_out <= '0;
      r_chan_out   <= '0;
      r_out_valid  <= 1'b0;
    end else if (clear) begin
      // The sample offered alongside clear is dropped. The output data holds.
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < N; i++) r_line[c][i] <= '0;
        r_ptr[c] <= '0;
        r_acc[c] <= '0;
      end
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every read in this block sees
      // pre-edge values, just as the combinational path above does.
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_line[w_chan][r_ptr[w_chan]] <= sample_in;
        r_ptr[w_chan]                 <= r_ptr[w_chan] + 1'b1;
        r_acc[w_chan]                 <= w_acc_next;
        r_sample_out                  <= bypass ? sample_in : w_avg;
        r_chan_out                    <= w_chan;
      end
    end
  end

  assign sample_out = r_sample_out;
  assign chan_out   = r_chan_out;
  assign out_valid  = r_out_valid;

endmodule
